// File: rtl/fb_scanout_reader.sv
// Raster-order framebuffer scanout: sweeps the RAM read port and streams pixels
// through a 2-entry credit-managed buffer. Define SCANOUT_LOOP_EN for continuous frames with stop.
module fb_scanout_reader #(
  parameter int DATA_W = 32,
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int DEPTH  = WIDTH * HEIGHT
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start,
`ifdef SCANOUT_LOOP_EN
  input  logic                       stop,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       rdEn,
  output logic [$clog2(DEPTH)-1:0]   rdAddr,
  input  logic [DATA_W-1:0]          rdData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [DATA_W-1:0]          outData,
  output logic                       outLast,
  output logic                       outFrameEnd
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic                infl_q;
  logic                infl_last_q;
  logic                infl_fe_q;
  logic [DATA_W-1:0]   buf_data_q [2];
  logic [1:0]          buf_last_q;
  logic [1:0]          buf_fe_q;
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic                stop_q;

  logic                x_last;
  logic                y_last;
  logic                frame_last;
  logic                pop;
  logic                head_fe;
  logic [1:0]          used;
  logic                keep_running;

  assign x_last     = (x_q == XW'(WIDTH - 1));
  assign y_last     = (y_q == YW'(HEIGHT - 1));
  assign frame_last = x_last && y_last;

  assign outValid    = (count_q != 2'd0);
  assign outData     = buf_data_q[rd_ptr_q];
  assign outLast     = buf_last_q[rd_ptr_q];
  assign outFrameEnd = buf_fe_q[rd_ptr_q];
  assign head_fe     = buf_fe_q[rd_ptr_q];
  assign pop         = outValid && outReady;

  // Credits count the entry leaving this cycle as free, so a full-rate stream never bubbles.
  assign used = count_q - {1'b0, pop} + {1'b0, infl_q};
  assign rdEn = (state_q == RUN) && (used < 2'd2);

  assign rdAddr = rd_addr_q;
  assign busy   = (state_q != IDLE);
  assign done   = pop && head_fe && (state_q != IDLE);

`ifdef SCANOUT_LOOP_EN
  assign keep_running = !(stop_q || stop);
`else
  assign keep_running = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_fe_q   <= 1'b0;
      for (int i = 0; i < 2; i++) buf_data_q[i] <= '0;
      buf_last_q  <= '0;
      buf_fe_q    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      stop_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            rd_addr_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            stop_q    <= 1'b0;
          end
        end
        RUN: begin
          if (rdEn && frame_last && !keep_running) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && head_fe) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

`ifdef SCANOUT_LOOP_EN
      if (state_q != IDLE && stop) stop_q <= 1'b1;
`endif

      if (rdEn) begin
        rd_addr_q <= frame_last ? '0 : rd_addr_q + 1'b1;
        x_q       <= x_last ? '0 : x_q + 1'b1;
        if (x_last) y_q <= y_last ? '0 : y_q + 1'b1;
      end

      // Tags travel with the read so they line up with rdData one cycle later.
      infl_q      <= rdEn;
      infl_last_q <= x_last;
      infl_fe_q   <= frame_last;

      if (infl_q) begin
        buf_data_q[wr_ptr_q] <= rdData;
        buf_last_q[wr_ptr_q] <= infl_last_q;
        buf_fe_q[wr_ptr_q]   <= infl_fe_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: RAM model with mem[i]=i, pixel-order scoreboard,
// credit/stability/busy model, plus directed timing checks.
module tb_fb_scanout_reader;
  localparam int DATA_W = 32;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 4;
  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              outReady = 1'b0;
  logic              busy, done, rdEn, outValid, outLast, outFrameEnd;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdData = '0;
  logic [DATA_W-1:0] outData;
  logic [DATA_W-1:0] mem [DEPTH];

  fb_scanout_reader #(.DATA_W(DATA_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .rstN(rstN), .start(start),
`ifdef SCANOUT_LOOP_EN
    .stop(stop),
`endif
    .busy(busy), .done(done), .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outLast(outLast), .outFrameEnd(outFrameEnd)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard and model state
  logic [DATA_W-1:0] exp_q [$];
  int start_cyc = 0;
  int exp_reads = 0;
  int n_reads = 0;
  int n_acc = 0;
  int exp_addr = 0;
  int frames_done = 0;
  int first_rden = -1;
  int xfer_rel [$];
  int done_rel [$];
  int last_data [$];
  bit model_busy = 1'b0;
  bit stop_seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic prev_last, prev_fe;

  always @(negedge clk) begin
    int rel, e, outstanding;
    bit p, busy_next, exp_fe;
    if (!rstN) begin
      exp_q.delete();
      n_reads = 0; n_acc = 0; exp_addr = 0;
      model_busy = 1'b0; stop_seen = 1'b0; prev_stall = 1'b0;
    end else begin
      rel = cyc - start_cyc;
      busy_next = model_busy;
      if (start && !model_busy) begin
        first_rden = -1; xfer_rel.delete(); done_rel.delete(); last_data.delete();
        n_reads = 0; n_acc = 0; exp_addr = 0;
      end
      p = outValid && outReady;
      outstanding = n_reads - n_acc;
      chk("busy", busy, model_busy);
      if (prev_stall) begin
        chk("stall_valid", outValid, 1);
        chk("stall_data", outData, prev_data);
        chk("stall_last", outLast, prev_last);
        chk("stall_fe", outFrameEnd, prev_fe);
      end
      if (p) begin
        if (exp_q.size() == 0) chk("extra_pixel", outValid, 0);
        else begin
          e = exp_q.pop_front();
          exp_fe = (e % DEPTH) == DEPTH - 1;
          chk("data", outData, e);
          chk("last", outLast, (e % WIDTH) == WIDTH - 1);
          chk("frame_end", outFrameEnd, exp_fe);
          chk("done", done, exp_fe);
          if (exp_fe) begin
            frames_done++;
`ifdef SCANOUT_LOOP_EN
            if (stop_seen) busy_next = 1'b0;
`else
            busy_next = 1'b0;
`endif
          end
        end
        xfer_rel.push_back(rel);
        if (outLast) last_data.push_back(int'(outData));
        n_acc++;
      end else chk("done_no_xfer", done, 0);
      if (done) done_rel.push_back(rel);
      if (!model_busy) chk("rden_idle", rdEn, 0);
      chk("credit", rdEn && (outstanding - int'(p) >= 2), 0);
      chk("rd_overrun", rdEn && (n_reads >= exp_reads), 0);
      if (rdEn) begin
        chk("rd_addr", rdAddr, exp_addr);
        if (first_rden < 0) first_rden = rel;
        n_reads++;
        exp_addr = (exp_addr + 1) % DEPTH;
      end
      if (stop && model_busy) stop_seen = 1'b1;
      if (start && !model_busy) begin busy_next = 1'b1; stop_seen = 1'b0; end
      model_busy = busy_next;
      prev_stall = outValid && !outReady;
      prev_data = outData; prev_last = outLast; prev_fe = outFrameEnd;
    end
  end

  function automatic logic ready_for(input int mode, input int rel);
    case (mode)
      1: return (rel % 3) == 0;
      2: return rel >= 10;
      default: return 1'b1;
    endcase
  endfunction

  // driver: one scan of 'frames' frames; mode selects outReady/start/stop pattern
  task automatic run_frame(input int mode, input int frames);
    int rel, target;
    for (int i = 0; i < DEPTH * frames; i++) exp_q.push_back(DATA_W'(i % DEPTH));
    exp_reads = DEPTH * frames;
    target = frames_done + frames;
    @(posedge clk); #1;
    start_cyc = cyc; start = 1'b1; outReady = ready_for(mode, 0);
    for (int k = 1; k < 400; k++) begin
      @(posedge clk); #1;
      rel = cyc - start_cyc;
      start = (mode == 3) && (rel == 5);
      stop  = (mode == 4) && (rel == 20);
      if (mode == 2 && rel == 10) begin
        chk("stall_reads", n_reads, 2);
        chk("stall_head_valid", outValid, 1);
        chk("stall_head_data", outData, 0);
      end
      outReady = ready_for(mode, rel);
      if (frames_done >= target) begin
        chk("busy_fall", busy, 0);
        break;
      end
    end
    chk("frames_done", frames_done, target);
    chk("exp_empty", exp_q.size(), 0);
    start = 1'b0; stop = 1'b0; outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, rdEn, 0);
    chk({tag, "_rdaddr"}, rdAddr, 0);
    chk({tag, "_valid"}, outValid, 0);
    chk({tag, "_data"}, outData, 0);
    chk({tag, "_last"}, outLast, 0);
    chk({tag, "_fe"}, outFrameEnd, 0);
  endtask

  initial begin
    bit seen6;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");

    // full-rate frame: latency and marker placement
    run_frame(0, 1);
    chk("first_rden_rel", first_rden, 1);
    chk("xfer_count", xfer_rel.size(), 16);
    chk("first_xfer_rel", xfer_rel.size() > 0 ? xfer_rel[0] : -1, 3);
    chk("last_xfer_rel", xfer_rel.size() > 15 ? xfer_rel[15] : -1, 18);
    chk("done_count", done_rel.size(), 1);
    chk("done_rel", done_rel.size() > 0 ? done_rel[0] : -1, 18);
    chk("last_count", last_data.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("last_pos", last_data.size() > i ? last_data[i] : -1, 4 * i + 3);

    // outReady pattern 1,0,0
    run_frame(1, 1);
    chk("toggle_xfers", xfer_rel.size(), 16);

    // ready held low 10 cycles after start
    run_frame(2, 1);
    chk("hold_xfers", xfer_rel.size(), 16);

    // start re-pulsed mid-frame
    run_frame(3, 1);
    chk("repulse_dones", done_rel.size(), 1);
    chk("repulse_xfers", xfer_rel.size(), 16);

    // reset while pixel 6 is at the head
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DATA_W'(i));
    exp_reads = DEPTH;
    @(posedge clk); #1;
    start_cyc = cyc; start = 1'b1; outReady = 1'b1;
    seen6 = 1'b0;
    for (int k = 0; k < 50 && !seen6; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (outValid && outData == 6) begin
        seen6 = 1'b1;
        outReady = 1'b0;
        rstN = 1'b0;
      end
    end
    chk("head6_seen", seen6, 1);
    @(posedge clk); #1;
    rstN = 1'b1; outReady = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    chk("abort_no_done", done_rel.size(), 0);
    run_frame(0, 1);
    chk("restart_first_rel", xfer_rel.size() > 0 ? xfer_rel[0] : -1, 3);
    chk("restart_xfers", xfer_rel.size(), 16);

`ifdef SCANOUT_LOOP_EN
    // two back-to-back frames, stop during frame 2
    run_frame(4, 2);
    chk("loop_dones", done_rel.size(), 2);
    chk("loop_done0", done_rel.size() > 0 ? done_rel[0] : -1, 18);
    chk("loop_done1", done_rel.size() > 1 ? done_rel[1] : -1, 34);
    chk("loop_xfers", xfer_rel.size(), 32);
    chk("loop_contig", xfer_rel.size() > 31 ? xfer_rel[31] : -1, 34);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
